// File: rtl/slurm32_cpu_hazard_ctrl_pkg.sv
// Shared definitions for the SLURM32 pipeline interlock: register select defaults,
// the hardwired-zero register and the load tracker state encoding.
package slurm32_cpu_hazard_ctrl_pkg;

  localparam int REGISTER_BITS_DEFAULT = 8;
  localparam logic [REGISTER_BITS_DEFAULT-1:0] ZERO_REGISTER = 8'd0;

  typedef enum logic [0:0] {
    HZ_IDLE    = 1'b0,
    HZ_PENDING = 1'b1
  } hz_state_t;

  // r0 is hardwired to zero, so a read of it can never depend on a writer.
  // Callers zero-extend their selects to 32 bits.
  function automatic logic reg_hit(input logic [31:0] sel, input logic [31:0] dst);
    return (sel != 32'(ZERO_REGISTER)) && (sel == dst);
  endfunction

endpackage

// File: rtl/slurm32_cpu_hazard_ctrl_scoreboard.sv
// In-flight register write tracker (slot 2 .. writeback) with per-port RAW match
// against the slot 1 register A/B selects.
module slurm32_cpu_scoreboard_pipe
  import slurm32_cpu_hazard_ctrl_pkg::*;
#(
  parameter int REGISTER_BITS = REGISTER_BITS_DEFAULT,
  parameter int PIPE_DEPTH    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ins_valid,
  input  logic [REGISTER_BITS-1:0] ins_reg,
  input  logic [REGISTER_BITS-1:0] rega_sel,
  input  logic [REGISTER_BITS-1:0] regb_sel,
  output logic                     match_a,
  output logic                     match_b
);

  // The writeback stage writes through to the register file, so it never hazards
  // and only the entries ahead of it (slot 2 .. PIPE_DEPTH-1) need storage.
  localparam int HZ_ENTRIES = PIPE_DEPTH - 1;

  logic [HZ_ENTRIES-1:0]    valid_q;
  logic [HZ_ENTRIES-1:0]    valid_d;
  logic [REGISTER_BITS-1:0] reg_q [HZ_ENTRIES];
  logic [REGISTER_BITS-1:0] reg_d [HZ_ENTRIES];

  always_comb begin
    valid_d[0] = ins_valid;
    reg_d[0]   = ins_reg;
    for (int i = 1; i < HZ_ENTRIES; i++) begin
      valid_d[i] = valid_q[i-1];
      reg_d[i]   = reg_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= {HZ_ENTRIES{1'b0}};
      for (int i = 0; i < HZ_ENTRIES; i++) begin
        reg_q[i] <= {REGISTER_BITS{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < HZ_ENTRIES; i++) begin
        reg_q[i] <= reg_d[i];
      end
    end
  end

  always_comb begin
    match_a = 1'b0;
    match_b = 1'b0;
    for (int i = 0; i < HZ_ENTRIES; i++) begin
      match_a = match_a | (valid_q[i] & reg_hit(32'(rega_sel), 32'(reg_q[i])));
      match_b = match_b | (valid_q[i] & reg_hit(32'(regb_sel), 32'(reg_q[i])));
    end
  end

endmodule

// File: rtl/slurm32_cpu_hazard_ctrl.sv
// SLURM32 pipeline interlock: combines scoreboard RAW matches with the single
// outstanding-load tracker to stall slots 0/1 and bubble slot 2.
module slurm32_cpu_hazard_ctrl
  import slurm32_cpu_hazard_ctrl_pkg::*;
#(
  parameter int REGISTER_BITS = REGISTER_BITS_DEFAULT,
  parameter int PIPE_DEPTH    = 3,
  parameter int CNT_BITS      = 16
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic                     dec_valid,
  input  logic [REGISTER_BITS-1:0] regA_sel,
  input  logic [REGISTER_BITS-1:0] regB_sel,
  input  logic                     dec_wr_en,
  input  logic [REGISTER_BITS-1:0] dec_wr_reg,
  input  logic                     dec_is_load,
  input  logic                     load_done,
  input  logic                     flush,
  output logic                     stall,
  output logic                     bubble,
  output logic                     load_pending,
  output logic [REGISTER_BITS-1:0] load_reg,
  output logic [CNT_BITS-1:0]      stall_count
);

  hz_state_t                state_q;
  hz_state_t                state_d;
  logic [REGISTER_BITS-1:0] load_reg_q;
  logic [REGISTER_BITS-1:0] load_reg_d;
  logic [CNT_BITS-1:0]      stall_count_q;
  logic [CNT_BITS-1:0]      stall_count_d;

  logic match_a;
  logic match_b;
  logic load_wait;
  logic load_raw;
  logic load_struct;
  logic load_waw;
  logic hazard;
  logic issue_load;
  logic sb_ins_valid;

  slurm32_cpu_scoreboard_pipe #(
    .REGISTER_BITS (REGISTER_BITS),
    .PIPE_DEPTH    (PIPE_DEPTH)
  ) u_scoreboard (
    .clk       (CLK),
    .rst       (RSTb),
    .ins_valid (sb_ins_valid),
    .ins_reg   (dec_wr_reg),
    .rega_sel  (regA_sel),
    .regb_sel  (regB_sel),
    .match_a   (match_a),
    .match_b   (match_b)
  );

  // Returning load data is written through, so load hazards drop in the done cycle.
  always_comb begin
    load_wait   = (state_q == HZ_PENDING) & ~load_done;
    load_raw    = load_wait & (reg_hit(32'(regA_sel), 32'(load_reg_q)) |
                               reg_hit(32'(regB_sel), 32'(load_reg_q)));
    load_struct = load_wait & dec_is_load;
    load_waw    = load_wait & dec_wr_en & (dec_wr_reg == load_reg_q);
    hazard      = match_a | match_b | load_raw | load_struct | load_waw;
    stall       = dec_valid & ~flush & hazard;
    bubble      = stall | flush;
    issue_load   = dec_valid & dec_is_load & ~stall & ~flush;
    sb_ins_valid = dec_valid & dec_wr_en & ~dec_is_load & ~stall & ~flush;
  end

  // A load issuing in the done cycle keeps the tracker busy with the new target.
  always_comb begin
    state_d    = state_q;
    load_reg_d = load_reg_q;
    case (state_q)
      HZ_IDLE: begin
        if (issue_load) begin
          state_d    = HZ_PENDING;
          load_reg_d = dec_wr_reg;
        end else begin
          state_d = HZ_IDLE;
        end
      end
      HZ_PENDING: begin
        if (issue_load) begin
          state_d    = HZ_PENDING;
          load_reg_d = dec_wr_reg;
        end else if (load_done) begin
          state_d = HZ_IDLE;
        end else begin
          state_d = HZ_PENDING;
        end
      end
      default: begin
        state_d = HZ_IDLE;
      end
    endcase
  end

  always_comb begin
    if (stall && (stall_count_q != {CNT_BITS{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_BITS'(1);
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTb) begin
      state_q       <= HZ_IDLE;
      load_reg_q    <= {REGISTER_BITS{1'b0}};
      stall_count_q <= {CNT_BITS{1'b0}};
    end else begin
      state_q       <= state_d;
      load_reg_q    <= load_reg_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign load_pending = (state_q == HZ_PENDING);
  assign load_reg     = load_reg_q;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_slurm32_cpu_hazard_ctrl.sv
// Directed bench for the SLURM32 interlock: per-cycle expectations are queued as
// stimulus is applied and checked against the DUT mid-cycle.
module tb_slurm32_cpu_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RSTb;
  logic       dec_valid;
  logic [7:0] regA_sel;
  logic [7:0] regB_sel;
  logic       dec_wr_en;
  logic [7:0] dec_wr_reg;
  logic       dec_is_load;
  logic       load_done;
  logic       flush;
  logic       stall;
  logic       bubble;
  logic       load_pending;
  logic [7:0] load_reg;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic       stall;
    logic       bubble;
    logic       pend;
    logic [7:0] lreg;
  } exp_t;

  exp_t exp_q[$];

  slurm32_cpu_hazard_ctrl dut (
    .CLK          (CLK),
    .RSTb         (RSTb),
    .dec_valid    (dec_valid),
    .regA_sel     (regA_sel),
    .regB_sel     (regB_sel),
    .dec_wr_en    (dec_wr_en),
    .dec_wr_reg   (dec_wr_reg),
    .dec_is_load  (dec_is_load),
    .load_done    (load_done),
    .flush        (flush),
    .stall        (stall),
    .bubble       (bubble),
    .load_pending (load_pending),
    .load_reg     (load_reg),
    .stall_count  (stall_count)
  );

  always #5 CLK = ~CLK;

  task automatic drv(input logic v, input logic [7:0] a, input logic [7:0] b,
                     input logic we, input logic [7:0] wr, input logic ld,
                     input logic done, input logic fl);
    dec_valid   = v;
    regA_sel    = a;
    regB_sel    = b;
    dec_wr_en   = we;
    dec_wr_reg  = wr;
    dec_is_load = ld;
    load_done   = done;
    flush       = fl;
  endtask

  // Queue this cycle's expectation, check it mid-cycle, then move to the next cycle.
  task automatic expect_cyc(input string tag, input logic s, input logic b,
                            input logic p, input logic [7:0] lr);
    exp_t e;
    exp_t got;
    e.tag = tag; e.stall = s; e.bubble = b; e.pend = p; e.lreg = lr;
    exp_q.push_back(e);
    #2;
    got = exp_q.pop_front();
    checks++;
    assert (stall === got.stall) else begin
      errors++;
      $error("FAIL %s stall: observed %0b expected %0b", got.tag, stall, got.stall);
    end
    checks++;
    assert (bubble === got.bubble) else begin
      errors++;
      $error("FAIL %s bubble: observed %0b expected %0b", got.tag, bubble, got.bubble);
    end
    checks++;
    assert (load_pending === got.pend) else begin
      errors++;
      $error("FAIL %s load_pending: observed %0b expected %0b", got.tag, load_pending, got.pend);
    end
    checks++;
    assert (load_reg === got.lreg) else begin
      errors++;
      $error("FAIL %s load_reg: observed %0d expected %0d", got.tag, load_reg, got.lreg);
    end
    @(negedge CLK);
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] exp_cnt);
    checks++;
    assert (stall_count === exp_cnt) else begin
      errors++;
      $error("FAIL %s stall_count: observed %0d expected %0d", tag, stall_count, exp_cnt);
    end
  endtask

  initial begin
    RSTb = 1'b1;
    drv(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTb = 1'b0;

    // Reset state and a read with nothing in flight.
    check_cnt("reset", 16'd0);
    drv(1'b1, 8'd5, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    expect_cyc("reset_read_r5", 1'b0, 1'b0, 1'b0, 8'd0);

    // Write r3, then a reader of r3 waits out slot 2 and stage 2 only.
    drv(1'b1, 8'd0, 8'd0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
    expect_cyc("wr_r3", 1'b0, 1'b0, 1'b0, 8'd0);
    drv(1'b1, 8'd3, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    expect_cyc("raw_r3_e1", 1'b1, 1'b1, 1'b0, 8'd0);
    expect_cyc("raw_r3_e2", 1'b1, 1'b1, 1'b0, 8'd0);
    expect_cyc("raw_r3_wb", 1'b0, 1'b0, 1'b0, 8'd0);
    check_cnt("raw_r3", 16'd2);

    // Load to r7, dependant on port B stalls until the data returns.
    drv(1'b1, 8'd0, 8'd0, 1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
    expect_cyc("ld_r7", 1'b0, 1'b0, 1'b0, 8'd0);
    drv(1'b1, 8'd0, 8'd7, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) expect_cyc("ld_raw_r7", 1'b1, 1'b1, 1'b1, 8'd7);
    drv(1'b1, 8'd0, 8'd7, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    expect_cyc("ld_done_r7", 1'b0, 1'b0, 1'b1, 8'd7);
    drv(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    expect_cyc("ld_idle", 1'b0, 1'b0, 1'b0, 8'd7);
    check_cnt("ld_raw", 16'd6);

    // Second load: structural stall, then back-to-back with load_done; then WAW.
    drv(1'b1, 8'd0, 8'd0, 1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
    expect_cyc("ld2_first", 1'b0, 1'b0, 1'b0, 8'd7);
    drv(1'b1, 8'd0, 8'd0, 1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
    expect_cyc("ld2_struct", 1'b1, 1'b1, 1'b1, 8'd7);
    drv(1'b1, 8'd0, 8'd0, 1'b1, 8'd9, 1'b1, 1'b1, 1'b0);
    expect_cyc("ld2_b2b", 1'b0, 1'b0, 1'b1, 8'd7);
    drv(1'b1, 8'd0, 8'd0, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
    expect_cyc("ld2_waw_r9", 1'b1, 1'b1, 1'b1, 8'd9);
    drv(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    expect_cyc("ld2_done", 1'b0, 1'b0, 1'b1, 8'd9);
    drv(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    expect_cyc("done_in_idle", 1'b0, 1'b0, 1'b0, 8'd9);
    check_cnt("ld2", 16'd8);

    // Writes to r0 are never a dependency.
    drv(1'b1, 8'd0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    expect_cyc("wr_r0", 1'b0, 1'b0, 1'b0, 8'd9);
    drv(1'b1, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    expect_cyc("rd_r0_e1", 1'b0, 1'b0, 1'b0, 8'd9);
    expect_cyc("rd_r0_e2", 1'b0, 1'b0, 1'b0, 8'd9);

    // Flush with a load outstanding: no stall, bubble, entry 1 killed, load kept.
    drv(1'b1, 8'd0, 8'd0, 1'b1, 8'd8, 1'b1, 1'b0, 1'b0);
    expect_cyc("fl_ld_r8", 1'b0, 1'b0, 1'b0, 8'd9);
    drv(1'b1, 8'd0, 8'd0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
    expect_cyc("fl_wr_r4", 1'b0, 1'b0, 1'b1, 8'd8);
    drv(1'b1, 8'd4, 8'd0, 1'b1, 8'd6, 1'b0, 1'b0, 1'b1);
    expect_cyc("flush", 1'b0, 1'b1, 1'b1, 8'd8);
    drv(1'b1, 8'd6, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    expect_cyc("post_flush_r6", 1'b0, 1'b0, 1'b1, 8'd8);
    drv(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    expect_cyc("fl_ld_done", 1'b0, 1'b0, 1'b1, 8'd8);
    drv(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    expect_cyc("fl_idle", 1'b0, 1'b0, 1'b0, 8'd8);
    check_cnt("flush", 16'd8);

    // Reset while a load is outstanding abandons it.
    drv(1'b1, 8'd0, 8'd0, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    expect_cyc("rst_ld_r5", 1'b0, 1'b0, 1'b0, 8'd8);
    drv(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    RSTb = 1'b1;
    @(negedge CLK);
    RSTb = 1'b0;
    drv(1'b1, 8'd5, 8'd5, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    expect_cyc("rst_mid_load", 1'b0, 1'b0, 1'b0, 8'd0);
    check_cnt("rst_mid_load", 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slurm32_cpu_hazard_ctrl.md
Name: slurm32_cpu_hazard_ctrl

Overview:
Pipeline interlock controller for the SLURM32 CPU. It tracks in-flight register writes and the single outstanding memory load. It compares them with the register A and B selects produced by the instruction decoder for pipeline slot 1. On a RAW or structural hazard it stalls slots 0/1 and injects a bubble into slot 2. It sits beside the decoder and drives the pipeline advance logic.

Parameters:
REGISTER_BITS, 8, width of register select fields (r0 reads as zero and never hazards)
PIPE_DEPTH, 3, number of stages from slot 2 through writeback; the last stage is the writeback stage
CNT_BITS, 16, width of the saturating stall-cycle performance counter

Ports:
CLK  in  1  system clock, all state updates on rising edge
RSTb  in  1  synchronous reset, active-high (asserted = 1, sampled on CLK)
dec_valid  in  1  slot 1 holds a valid instruction
regA_sel  in  REGISTER_BITS  decoder register A select, slot 1
regB_sel  in  REGISTER_BITS  decoder register B select, slot 1
dec_wr_en  in  1  slot 1 instruction writes a register
dec_wr_reg  in  REGISTER_BITS  slot 1 destination register
dec_is_load  in  1  slot 1 instruction is a memory load (variable latency)
load_done  in  1  memory returns load data this cycle; it is written with write-through
flush  in  1  taken branch/interrupt: kill slot 1 and stage 1 (younger instructions)
stall  out  1  hold slots 0 and 1 this cycle
bubble  out  1  slot 2 receives a NOP this cycle
load_pending  out  1  one load is outstanding
load_reg  out  REGISTER_BITS  destination of the outstanding load
stall_count  out  CNT_BITS  saturating count of stalled cycles

Behaviour:
- Pipe scoreboard: PIPE_DEPTH entries {valid, wr_reg}. Entry 1 is slot 2 and entry PIPE_DEPTH is writeback.
  - All entries shift one place every cycle; downstream never stalls.
  - Entry 1 loads {dec_valid & dec_wr_en & ~dec_is_load & ~stall & ~flush, dec_wr_reg}. Otherwise it loads invalid.
  - Loads are tracked only by the load FSM, not by the scoreboard.
- RAW hazard, evaluated combinationally in the same cycle:
  - A hazard exists if dec_valid and (regA_sel or regB_sel) is non-zero and equals wr_reg of a valid entry 1..PIPE_DEPTH-1.
  - The writeback entry never hazards, because the register file writes through.
- Load FSM, states IDLE and PENDING:
  - IDLE -> PENDING when dec_valid & dec_is_load & ~stall & ~flush. load_reg latches dec_wr_reg on that edge.
  - PENDING -> IDLE on load_done, unless a new load issues in the same cycle. In that case stay in PENDING and latch the new load_reg.
  - In PENDING with load_done=0:
    - RAW hazard if a non-zero regA_sel/regB_sel equals load_reg.
    - Structural hazard if dec_is_load.
  - In PENDING with load_done=1, neither hazard applies that cycle.
- Destination-order hazard (WAW): in PENDING with load_done=0, a hazard exists if dec_wr_en and dec_wr_reg == load_reg.
- stall = dec_valid & ~flush & (any hazard). bubble = stall | flush.
- Flush:
  - Invalidates entry 1 on the next edge.
  - Forces stall=0 for the current cycle.
  - Does not cancel an outstanding load: PENDING persists until load_done.
- load_done in IDLE is ignored (no state change).
- stall_count increments on every cycle with stall=1 and saturates at all-ones.
- Reset: all entries invalid, FSM in IDLE, load_reg=0, stall_count=0. As a result stall=0, bubble=0 and load_pending=0 in the first cycle after reset. Reset mid-load abandons the load.
- Latency: the hazard decision is combinational, with 0 cycles from the inputs to stall.

Decomposition:
- Shared package (slurm32_cpu_decode_functions.v / common include): REGISTER_BITS default, ZERO_REGISTER, FSM state encodings (HZ_IDLE, HZ_PENDING).
- One natural sub-module, slurm32_cpu_scoreboard_pipe: the PIPE_DEPTH shift register plus its match comparator. It outputs a per-port match for regA and regB.
- The load FSM, hazard OR, and counter stay in the top level.

Test Plan:
- Reset held 2 cycles, then released -> stall=0, bubble=0, load_pending=0, stall_count=0. Driving dec_valid=1 with regA_sel=5 gives no stall.
- Write r3 issued (dec_wr_en=1, dec_wr_reg=3). Next cycle, an instruction with regA_sel=3 -> stall=1 for PIPE_DEPTH-1=2 cycles, then stall=0; stall_count=2.
- Load to r7, no load_done for 4 cycles. A dependant with regB_sel=7 -> stall=1 for 4 cycles. load_done=1 in the next cycle -> stall=0 that cycle and FSM returns to IDLE.
- Load pending to r7 and a second load presented -> stall=1. With load_done and the second load (to r9) in the same cycle -> stall=0, load_pending stays 1, load_reg=9.
- Instruction with regA_sel=0 and a pending write to r0 -> never stalls.
- Write r4 issued, then flush=1 next cycle with regA_sel=4 in slot 1 -> stall=0, bubble=1. Entry 1 is invalid afterwards. An outstanding load stays pending through the flush.
